// File: rtl/ram_alu_if.sv
// ram_alu_if: bundles the request/response handshake and the RAM_ALU bus
// driven by ram_alu_master.
//   master modport : the sequencer side (drives req_ready, rsp_*, alu_* except alu_dout)
//   slave modport  : the client/slave side (drives req_*, rsp_ready, alu_dout)
// Signals:
//   req_valid/req_ready/req_op/req_x/req_y  request port
//   rsp_valid/rsp_ready/rsp_data/rsp_err    response port
//   alu_e/alu_op/alu_din/alu_addr/alu_w/alu_r/alu_dout  RAM_ALU bus
interface ram_alu_if #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_x;
  logic [DATA_W-1:0] req_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_data;
  logic              rsp_err;
  logic              alu_e;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_din;
  logic [1:0]        alu_addr;
  logic              alu_w;
  logic              alu_r;
  logic [RES_W-1:0]  alu_dout;

  modport master (
    input  req_valid, req_op, req_x, req_y, rsp_ready, alu_dout,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output alu_e, alu_op, alu_din, alu_addr, alu_w, alu_r
  );

  modport slave (
    output req_valid, req_op, req_x, req_y, rsp_ready, alu_dout,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  alu_e, alu_op, alu_din, alu_addr, alu_w, alu_r
  );
endinterface

// File: rtl/ram_alu_master.sv
// ram_alu_master: initiator for a RAM_ALU slave. Accepts one (op, X, Y)
// request, writes X to addr 0, Y to addr 1, reads the result from addr 2 and
// returns it on the response port. All outputs are registered.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  ram_alu_if.master (request, response and RAM_ALU bus signals)
// Parameters:
//   DATA_W operand width, RES_W result width,
//   HOLD_CYC cycles per write phase (>=1), READ_LAT cycles of read before sampling (>=1)
module ram_alu_master #(
  parameter int DATA_W   = 16,
  parameter int RES_W    = 32,
  parameter int HOLD_CYC = 1,
  parameter int READ_LAT = 2
) (
  input logic      clk,
  input logic      rst,
  ram_alu_if.master bus
);

  localparam int MAX_CYC = (HOLD_CYC > READ_LAT) ? HOLD_CYC : READ_LAT;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_X = 3'd1,
    S_WR_Y = 3'd2,
    S_RD   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] y_r;
  logic              err_r;

  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [RES_W-1:0]  rsp_data_r;
  logic              rsp_err_r;
  logic              alu_e_r;
  logic [1:0]        alu_op_r;
  logic [DATA_W-1:0] alu_din_r;
  logic [1:0]        alu_addr_r;
  logic              alu_w_r;
  logic              alu_r_r;

  // Divisor-zero flag: op1/op2 divide by Y, op3 divides by X-Y.
  function automatic logic div_zero(input logic [1:0] op,
                                    input logic [DATA_W-1:0] x,
                                    input logic [DATA_W-1:0] y);
    logic res;
    case (op)
      2'd1:    res = (y == '0);
      2'd2:    res = (y == '0);
      2'd3:    res = (x == y);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Sequencer: outputs are loaded for the state being entered, so each bus
  // phase appears on the cycle right after the edge that starts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= CNT_ZERO;
      y_r         <= '0;
      err_r       <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_err_r   <= 1'b0;
      alu_e_r     <= 1'b0;
      alu_op_r    <= 2'd0;
      alu_din_r   <= '0;
      alu_addr_r  <= 2'd0;
      alu_w_r     <= 1'b0;
      alu_r_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.req_valid && req_ready_r) begin
            y_r         <= bus.req_y;
            err_r       <= div_zero(bus.req_op, bus.req_x, bus.req_y);
            req_ready_r <= 1'b0;
            alu_e_r     <= 1'b1;
            alu_op_r    <= bus.req_op;
            alu_addr_r  <= 2'd0;
            alu_din_r   <= bus.req_x;
            alu_w_r     <= 1'b1;
            alu_r_r     <= 1'b0;
            cnt_r       <= HOLD_LAST;
            state_r     <= S_WR_X;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        S_WR_X: begin
          if (cnt_r == CNT_ZERO) begin
            alu_addr_r <= 2'd1;
            alu_din_r  <= y_r;
            cnt_r      <= HOLD_LAST;
            state_r    <= S_WR_Y;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        S_WR_Y: begin
          if (cnt_r == CNT_ZERO) begin
            alu_addr_r <= 2'd2;
            alu_w_r    <= 1'b0;
            alu_r_r    <= 1'b1;
            cnt_r      <= READ_LAST;
            state_r    <= S_RD;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        S_RD: begin
          if (cnt_r == CNT_ZERO) begin
            // Sample the slave at the edge closing the last read cycle.
            rsp_data_r  <= bus.alu_dout;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_r;
            alu_e_r     <= 1'b0;
            alu_w_r     <= 1'b0;
            alu_r_r     <= 1'b0;
            state_r     <= S_RESP;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        S_RESP: begin
          // req_ready only rises after the handshake edge: no same-cycle re-accept.
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          alu_e_r     <= 1'b0;
          alu_w_r     <= 1'b0;
          alu_r_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.alu_e     = alu_e_r;
  assign bus.alu_op    = alu_op_r;
  assign bus.alu_din   = alu_din_r;
  assign bus.alu_addr  = alu_addr_r;
  assign bus.alu_w     = alu_w_r;
  assign bus.alu_r     = alu_r_r;

endmodule

// File: tb/tb_ram_alu_master.sv
// tb_ram_alu_master: two masters (HOLD_CYC=1/READ_LAT=2 and HOLD_CYC=3/READ_LAT=1)
// each driving a behavioural RAM_ALU slave. A transaction-level model predicts
// every output from the cycle count since accept; directed tests add literal checks.
module tb_ram_alu_master;

  localparam int H0 = 1;
  localparam int R0 = 2;
  localparam int H1 = 3;
  localparam int R1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  ram_alu_if #(.DATA_W(16), .RES_W(32)) ifa ();
  ram_alu_if #(.DATA_W(16), .RES_W(32)) ifb ();

  ram_alu_master #(.DATA_W(16), .RES_W(32), .HOLD_CYC(H0), .READ_LAT(R0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  ram_alu_master #(.DATA_W(16), .RES_W(32), .HOLD_CYC(H1), .READ_LAT(R1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Reference arithmetic of the RAM_ALU slave.
  function automatic logic [31:0] calc(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] a, b, d;
    a = {16'd0, x};
    b = {16'd0, y};
    d = a - b;
    case (op)
      2'd0:    return (a + b) * (a - b);
      2'd1:    return (b == 32'd0) ? 32'd0 : a % b;
      2'd2:    return (b == 32'd0) ? 32'd0 : a / b;
      2'd3:    return (d == 32'd0) ? 32'd0 : a % d;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Flattened view of both instances.
  logic [1:0]  v_valid, v_rspr, v_rdy, v_rv, v_err, v_e, v_w, v_r;
  logic [1:0]  v_op [2];
  logic [1:0]  v_aop [2];
  logic [1:0]  v_addr [2];
  logic [15:0] v_x [2];
  logic [15:0] v_y [2];
  logic [15:0] v_din [2];
  logic [31:0] v_data [2];

  assign v_valid[0] = ifa.req_valid;  assign v_valid[1] = ifb.req_valid;
  assign v_rspr[0]  = ifa.rsp_ready;  assign v_rspr[1]  = ifb.rsp_ready;
  assign v_rdy[0]   = ifa.req_ready;  assign v_rdy[1]   = ifb.req_ready;
  assign v_rv[0]    = ifa.rsp_valid;  assign v_rv[1]    = ifb.rsp_valid;
  assign v_err[0]   = ifa.rsp_err;    assign v_err[1]   = ifb.rsp_err;
  assign v_e[0]     = ifa.alu_e;      assign v_e[1]     = ifb.alu_e;
  assign v_w[0]     = ifa.alu_w;      assign v_w[1]     = ifb.alu_w;
  assign v_r[0]     = ifa.alu_r;      assign v_r[1]     = ifb.alu_r;
  assign v_op[0]    = ifa.req_op;     assign v_op[1]    = ifb.req_op;
  assign v_aop[0]   = ifa.alu_op;     assign v_aop[1]   = ifb.alu_op;
  assign v_addr[0]  = ifa.alu_addr;   assign v_addr[1]  = ifb.alu_addr;
  assign v_x[0]     = ifa.req_x;      assign v_x[1]     = ifb.req_x;
  assign v_y[0]     = ifa.req_y;      assign v_y[1]     = ifb.req_y;
  assign v_din[0]   = ifa.alu_din;    assign v_din[1]   = ifb.alu_din;
  assign v_data[0]  = ifa.rsp_data;   assign v_data[1]  = ifb.rsp_data;

  // Behavioural slaves: registers at addr 0/1, combinational result.
  logic [15:0] s_reg0 [2];
  logic [15:0] s_reg1 [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (v_e[i] && v_w[i] && v_addr[i] == 2'd0) s_reg0[i] <= v_din[i];
      if (v_e[i] && v_w[i] && v_addr[i] == 2'd1) s_reg1[i] <= v_din[i];
    end
  end
  assign ifa.alu_dout = calc(ifa.alu_op, s_reg0[0], s_reg1[0]);
  assign ifb.alu_dout = calc(ifb.alu_op, s_reg0[1], s_reg1[1]);

  // Transaction model: m_p counts cycles since the accept edge.
  int          hc [2] = '{H0, H1};
  int          rl [2] = '{R0, R1};
  bit          m_live [2] = '{1'b0, 1'b0};
  bit          m_busy [2];
  bit          m_rv [2];
  bit          m_err [2];
  int          m_p [2];
  logic [1:0]  m_op [2];
  logic [15:0] m_x [2];
  logic [15:0] m_y [2];
  logic [31:0] m_data [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_live[i] <= 1'b1;
        m_busy[i] <= 1'b0;
        m_rv[i]   <= 1'b0;
        m_op[i]   <= 2'd0;
      end else if (!m_busy[i]) begin
        if (v_valid[i]) begin
          m_busy[i] <= 1'b1;
          m_p[i]    <= 0;
          m_op[i]   <= v_op[i];
          m_x[i]    <= v_x[i];
          m_y[i]    <= v_y[i];
        end
      end else if (m_rv[i]) begin
        if (v_rspr[i]) begin
          m_busy[i] <= 1'b0;
          m_rv[i]   <= 1'b0;
        end
      end else begin
        m_p[i] <= m_p[i] + 1;
        if (m_p[i] + 1 == 2 * hc[i] + rl[i]) begin
          m_rv[i]   <= 1'b1;
          m_data[i] <= calc(m_op[i], m_x[i], m_y[i]);
          m_err[i]  <= ((m_op[i] == 2'd1 || m_op[i] == 2'd2) && m_y[i] == 16'd0) ||
                       (m_op[i] == 2'd3 && m_x[i] == m_y[i]);
        end
      end
    end
  end

  // Compare process, on the falling edge.
  logic        x_e, x_w, x_r;
  logic [1:0]  x_addr;
  logic [15:0] x_din;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_live[i]) begin
        x_e = 1'b0; x_w = 1'b0; x_r = 1'b0; x_addr = 2'd0; x_din = 16'd0;
        if (m_busy[i] && m_p[i] < hc[i]) begin
          x_e = 1'b1; x_w = 1'b1; x_addr = 2'd0; x_din = m_x[i];
        end else if (m_busy[i] && m_p[i] < 2 * hc[i]) begin
          x_e = 1'b1; x_w = 1'b1; x_addr = 2'd1; x_din = m_y[i];
        end else if (m_busy[i] && m_p[i] < 2 * hc[i] + rl[i]) begin
          x_e = 1'b1; x_r = 1'b1; x_addr = 2'd2; x_din = m_y[i];
        end
        chk("req_ready", i, 32'(v_rdy[i]), 32'(!m_busy[i]));
        chk("alu_e", i, 32'(v_e[i]), 32'(x_e));
        chk("alu_w", i, 32'(v_w[i]), 32'(x_w));
        chk("alu_r", i, 32'(v_r[i]), 32'(x_r));
        chk("alu_op", i, 32'(v_aop[i]), 32'(m_op[i]));
        if (x_e) begin
          chk("alu_addr", i, 32'(v_addr[i]), 32'(x_addr));
          chk("alu_din", i, 32'(v_din[i]), 32'(x_din));
        end
        chk("rsp_valid", i, 32'(v_rv[i]), 32'(m_rv[i]));
        if (m_rv[i]) begin
          chk("rsp_data", i, v_data[i], m_data[i]);
          chk("rsp_err", i, 32'(v_err[i]), 32'(m_err[i]));
        end
      end
    end
  end

  task automatic chk_reset_a(input string nm);
    chk({nm, "_ready"}, 0, 32'(ifa.req_ready), 32'd1);
    chk({nm, "_rv"}, 0, 32'(ifa.rsp_valid), 32'd0);
    chk({nm, "_data"}, 0, ifa.rsp_data, 32'd0);
    chk({nm, "_err"}, 0, 32'(ifa.rsp_err), 32'd0);
    chk({nm, "_bus"}, 0, {10'd0, ifa.alu_e, ifa.alu_op, ifa.alu_din, ifa.alu_addr, ifa.alu_w, ifa.alu_r}, 32'd0);
  endtask

  // One transaction on instance A, called at a falling edge with req_ready=1.
  task automatic run_a(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] ed, input logic ee, input int stall, input bit junk);
    int n;
    ifa.req_valid = 1'b1; ifa.req_op = op; ifa.req_x = x; ifa.req_y = y;
    @(negedge clk);
    ifa.req_valid = 1'b0; ifa.req_x = 16'hDEAD; ifa.req_y = 16'hBEEF;
    n = 0;
    while (!ifa.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 0, 32'(n), 32'd4);
    chk("lit_data", 0, ifa.rsp_data, ed);
    chk("lit_err", 0, 32'(ifa.rsp_err), 32'(ee));
    chk("busy_ready", 0, 32'(ifa.req_ready), 32'd0);
    for (int k = 0; k < stall; k++) begin
      if (junk) begin
        ifa.req_valid = 1'b1; ifa.req_op = 2'd0; ifa.req_x = 16'd1; ifa.req_y = 16'd1;
      end
      @(negedge clk);
      chk("stall_rv", 0, 32'(ifa.rsp_valid), 32'd1);
      chk("stall_data", 0, ifa.rsp_data, ed);
      chk("stall_ready", 0, 32'(ifa.req_ready), 32'd0);
    end
    ifa.req_valid = 1'b0;
    ifa.rsp_ready = 1'b1;
    @(negedge clk);
    ifa.rsp_ready = 1'b0;
    chk("post_ready", 0, 32'(ifa.req_ready), 32'd1);
    chk("post_rv", 0, 32'(ifa.rsp_valid), 32'd0);
  endtask

  initial begin
    int n, wc, rc;
    ifa.req_valid = 1'b0; ifa.req_op = 2'd0; ifa.req_x = 16'd0; ifa.req_y = 16'd0; ifa.rsp_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_op = 2'd0; ifb.req_x = 16'd0; ifb.req_y = 16'd0; ifb.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_a("rst");

    run_a(2'd0, 16'd4, 16'd5, 32'hFFFF_FFF7, 1'b0, 0, 1'b0);
    run_a(2'd0, 16'd445, 16'd100, 32'd188025, 1'b0, 0, 1'b0);
    run_a(2'd1, 16'd445, 16'd100, 32'd45, 1'b0, 0, 1'b0);
    run_a(2'd2, 16'd445, 16'd100, 32'd4, 1'b0, 0, 1'b0);
    run_a(2'd3, 16'd445, 16'd100, 32'd100, 1'b0, 0, 1'b0);
    run_a(2'd2, 16'd65535, 16'd0, 32'd0, 1'b1, 0, 1'b0);
    run_a(2'd3, 16'd65535, 16'd65535, 32'd0, 1'b1, 0, 1'b0);
    run_a(2'd1, 16'd65535, 16'd65535, 32'd0, 1'b0, 0, 1'b0);
    run_a(2'd1, 16'd445, 16'd100, 32'd45, 1'b0, 10, 1'b1);

    // Reset while writing Y: transaction dropped.
    ifa.req_valid = 1'b1; ifa.req_op = 2'd0; ifa.req_x = 16'd7; ifa.req_y = 16'd3;
    @(negedge clk);
    ifa.req_valid = 1'b0;
    @(negedge clk);
    chk("in_wr_y", 0, 32'(ifa.alu_addr), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_a("midrst");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("no_rsp", 0, 32'(ifa.rsp_valid), 32'd0);
    end
    run_a(2'd0, 16'd7, 16'd3, 32'd40, 1'b0, 0, 1'b0);

    // Instance B: HOLD_CYC=3, READ_LAT=1.
    ifb.req_valid = 1'b1; ifb.req_op = 2'd2; ifb.req_x = 16'd445; ifb.req_y = 16'd100;
    @(negedge clk);
    ifb.req_valid = 1'b0;
    n = 0; wc = 0; rc = 0;
    while (!ifb.rsp_valid && n < 30) begin
      wc += int'(ifb.alu_w);
      rc += int'(ifb.alu_r);
      @(negedge clk);
      n++;
    end
    chk("b_latency", 1, 32'(n), 32'd7);
    chk("b_wcycles", 1, 32'(wc), 32'd6);
    chk("b_rcycles", 1, 32'(rc), 32'd1);
    chk("b_data", 1, ifb.rsp_data, 32'd4);
    ifb.rsp_ready = 1'b1;
    @(negedge clk);
    ifb.rsp_ready = 1'b0;
    chk("b_post_ready", 1, 32'(ifb.req_ready), 32'd1);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
